// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared owner encoding and default sizes for the SRAM port arbiter
package sram_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_INST = 2'd1, RD_DATA = 2'd2} owner_t;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_STARVE_MAX = 3;
endpackage

// File: rtl/sram_port_arbiter_hold_reg.sv
// arb_hold_reg: per-port return valid, last-word hold register and read-data mux
module arb_hold_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ret,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] hold;
  always_ff @(posedge clk or negedge rst)
    if (!rst) hold <= '0;
    else if (ret) hold <= sram_rdata;
  assign rvalid = ret;
  assign rdata = ret ? sram_rdata : hold;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between fetch and data with a fetch starvation guard
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
);
  owner_t owner, owner_nx;
  logic [3:0] starve_cnt;
  logic force_inst, inst_ret, data_ret;
  // rst gates everything combinational so all outputs read 0 during reset
  assign force_inst = inst_req & (starve_cnt == 4'(STARVE_MAX));
  assign data_gnt = rst & data_req & ~force_inst;
  assign inst_gnt = rst & inst_req & ~data_gnt;
  assign stallreq_if = rst & inst_req & ~inst_gnt;
  assign stallreq_mem = rst & data_req & ~data_gnt;
  assign sram_en = inst_gnt | data_gnt;
  assign sram_addr = data_gnt ? data_addr : inst_gnt ? inst_addr : '0;
  assign sram_wen = data_gnt ? data_wen : 4'd0;
  assign sram_wdata = data_gnt ? data_wdata : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) starve_cnt <= 4'd0;
    else if (!inst_req || inst_gnt) starve_cnt <= 4'd0;
    else if (data_gnt && starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) owner <= IDLE;
    else owner <= owner_nx;
  always_comb
    owner_nx = inst_gnt ? RD_INST : (data_gnt && data_wen == 4'd0) ? RD_DATA : IDLE;
  always_comb begin
    inst_ret = owner == RD_INST;
    data_ret = owner == RD_DATA;
  end
  arb_hold_reg #(.DATA_W(DATA_W)) u_inst_hold (
    .clk(clk), .rst(rst), .ret(inst_ret), .sram_rdata(sram_rdata),
    .rvalid(inst_rvalid), .rdata(inst_rdata)
  );
  arb_hold_reg #(.DATA_W(DATA_W)) u_data_hold (
    .clk(clk), .rst(rst), .ret(data_ret), .sram_rdata(sram_rdata),
    .rvalid(data_rvalid), .rdata(data_rdata)
  );
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of grants, starvation guard, return path and reset
module tb_sram_port_arbiter;
  logic clk = 0, rst = 0;
  logic inst_req = 0, data_req = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0;
  logic [3:0] data_wen = 0;
  logic inst_gnt, inst_rvalid, data_gnt, data_rvalid, sram_en, stallreq_if, stallreq_mem;
  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic [31:0] sram_rdata = 0;
  logic [3:0] sram_wen;
  logic [31:0] mem [logic [31:0]];
  int checks = 0, failures = 0;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [31:0] t;
    if (sram_en) begin
      if (sram_wen == 4'd0) sram_rdata <= mem[sram_addr];
      else begin
        t = mem[sram_addr];
        for (int b = 0; b < 4; b++) if (sram_wen[b]) t[8*b +: 8] = sram_wdata[8*b +: 8];
        mem[sram_addr] = t;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[32'h100] = 32'hAABBCCDD;
    mem[32'h104] = 32'h01020304;
    mem[32'h108] = 32'h0BADBEEF;
    mem[32'h10C] = 32'hCAFEF00D;
    mem[32'h200] = 32'h11223344;
    mem[32'h204] = 32'h55667788;
    mem[32'h300] = 32'h00000000;
    inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200;
    #12;
    chk("rst_inst_gnt", inst_gnt, 0);
    chk("rst_data_gnt", data_gnt, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_stall_if", stallreq_if, 0);
    chk("rst_stall_mem", stallreq_mem, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    inst_req = 0; data_req = 0;
    #10 rst = 1;
    // fetch-only read
    step();
    inst_req = 1; inst_addr = 32'h100;
    #1;
    chk("f_gnt", inst_gnt, 1);
    chk("f_sram_addr", sram_addr, 32'h100);
    chk("f_sram_wen", sram_wen, 0);
    step();
    inst_req = 0;
    #1;
    chk("f_rvalid", inst_rvalid, 1);
    chk("f_rdata", inst_rdata, 32'hAABBCCDD);
    step(); step();
    chk("f_hold_rvalid", inst_rvalid, 0);
    chk("f_hold_rdata", inst_rdata, 32'hAABBCCDD);
    // simultaneous reads: data wins
    inst_req = 1; inst_addr = 32'h104; data_req = 1; data_wen = 0; data_addr = 32'h200;
    #1;
    chk("s_data_gnt", data_gnt, 1);
    chk("s_inst_gnt", inst_gnt, 0);
    chk("s_stall_if", stallreq_if, 1);
    chk("s_sram_addr", sram_addr, 32'h200);
    step();
    inst_req = 0; data_req = 0;
    #1;
    chk("s_data_rvalid", data_rvalid, 1);
    chk("s_data_rdata", data_rdata, 32'h11223344);
    chk("s_inst_rvalid", inst_rvalid, 0);
    step();
    // starvation guard: data wins 3 times, fetch forced on the 4th, data again on the 5th
    inst_req = 1; inst_addr = 32'h108; data_req = 1; data_addr = 32'h204;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("sv_data_gnt%0d", i), data_gnt, (i != 3) ? 1 : 0);
      chk($sformatf("sv_inst_gnt%0d", i), inst_gnt, (i == 3) ? 1 : 0);
      chk($sformatf("sv_stall_mem%0d", i), stallreq_mem, (i == 3) ? 1 : 0);
      if (i == 3) chk("sv_inst_rdata", inst_rdata, 32'hAABBCCDD);
      step();
      if (i == 4) chk("sv_last_data_rdata", data_rdata, 32'h55667788);
    end
    // store: no return, hold unchanged
    inst_req = 0; data_wen = 4'b0011; data_addr = 32'h300; data_wdata = 32'h1234;
    #1;
    chk("w_sram_en", sram_en, 1);
    chk("w_sram_wen", sram_wen, 4'b0011);
    chk("w_sram_wdata", sram_wdata, 32'h1234);
    chk("w_sram_addr", sram_addr, 32'h300);
    step();
    data_req = 0; data_wen = 0;
    #1;
    chk("w_data_rvalid", data_rvalid, 0);
    chk("w_data_rdata", data_rdata, 32'h55667788);
    step();
    // back-to-back data read then fetch
    data_req = 1; data_addr = 32'h300;
    #1;
    chk("bb_data_gnt", data_gnt, 1);
    step();
    data_req = 0; inst_req = 1; inst_addr = 32'h10C;
    #1;
    chk("bb_data_rvalid", data_rvalid, 1);
    chk("bb_data_rdata", data_rdata, 32'h00001234);
    chk("bb_inst_gnt", inst_gnt, 1);
    chk("bb_inst_rvalid1", inst_rvalid, 0);
    step();
    inst_req = 0;
    #1;
    chk("bb_inst_rvalid2", inst_rvalid, 1);
    chk("bb_data_rvalid2", data_rvalid, 0);
    chk("bb_inst_rdata", inst_rdata, 32'hCAFEF00D);
    step();
    // mid-read reset
    inst_req = 1; inst_addr = 32'h100;
    #1;
    chk("mr_gnt", inst_gnt, 1);
    step();
    rst = 0;
    #1;
    chk("mr_rvalid", inst_rvalid, 0);
    chk("mr_rdata", inst_rdata, 0);
    chk("mr_gnt_in_rst", inst_gnt, 0);
    chk("mr_stall_in_rst", stallreq_if, 0);
    chk("mr_en_in_rst", sram_en, 0);
    step(); step();
    rst = 1; inst_req = 0;
    #1;
    chk("mr_post_rvalid", inst_rvalid, 0);
    chk("mr_post_gnt", data_gnt | inst_gnt, 0);
    step();
    chk("mr_post2_rvalid", inst_rvalid, 0);
    chk("mr_post2_rdata", inst_rdata, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
